// File: rtl/pipelined_adder.sv
// Carry-pipelined two's-complement adder/subtractor with valid/ready flow control.
// Optional macro ADDER_SAT_EN saturates the sum on signed overflow.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Level 0 is the operand capture register; level k+1 holds the result of chunk k.
  logic [STAGES:0]  vld_q, vld_d;
  logic [STAGES:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [STAGES+1];
  logic [WIDTH-1:0] a_d [STAGES+1];
  logic [WIDTH-1:0] b_q [STAGES+1];
  logic [WIDTH-1:0] b_d [STAGES+1];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [WIDTH-1:0] s_d [STAGES+1];
  logic [CW:0]      part [STAGES];
  logic             stall;

  assign stall    = vld_q[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = sub ? ~b : b;
    s_d[0]   = '0;
    c_d[0]   = cin ^ sub;
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_q[k][k*CW +: CW]} + {1'b0, b_q[k][k*CW +: CW]}
              + {{CW{1'b0}}, c_q[k]};
      vld_d[k+1]            = vld_q[k];
      a_d[k+1]              = a_q[k];
      b_d[k+1]              = b_q[k];
      s_d[k+1]              = s_q[k];
      s_d[k+1][k*CW +: CW]  = part[k][CW-1:0];
      c_d[k+1]              = part[k][CW];
    end
  end

  // A stall freezes the whole pipe so nothing can be overwritten or duplicated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      for (int k = 0; k <= STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;

  assign raw       = s_q[STAGES];
  assign a_msb     = a_q[STAGES][WIDTH-1];
  assign b_msb     = b_q[STAGES][WIDTH-1];
  assign out_valid = vld_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef ADDER_SAT_EN
  // Clamp toward the sign of the operands that overflowed.
  assign sum = !ovf ? raw
             : a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
             : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum = raw;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;

  pipelined_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated transaction: checks it is absent one cycle early and correct on time.
  task automatic send_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vcin, input logic vsub, input logic [31:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vcin;
    sub = vsub;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES - 1) @(negedge clk);
    check({tag, "_early"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  logic [31:0] sat_pos;
  logic [31:0] sat_neg;

  initial begin
`ifdef ADDER_SAT_EN
    sat_pos = 32'h7FFF_FFFF;
    sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'h8000_0000;
    sat_neg = 32'h7FFF_FFFF;
`endif
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));

    send_one("inc_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send_one("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, sat_pos,       1'b0, 1'b1);
    send_one("sub_5_3",  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send_one("sub_neg",  32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 1'b0);
    send_one("cin_rip",  32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0);
    send_one("sub_brw",  32'h0000_0010, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_000A, 1'b1, 1'b0);
    send_one("zero_m1",  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_one("neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, sat_neg,       1'b1, 1'b1);

    // Back-to-back: trans i enters before edge i, visible at the negedge of iteration i+5.
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) check($sformatf("b2b_gap%0d", c), 64'(out_valid), 64'(0));
      if (c >= 5 && c <= 12) begin
        check($sformatf("b2b_v%0d", c - 5), 64'(out_valid), 64'(1));
        check($sformatf("b2b_s%0d", c - 5), 64'(sum), 64'(2 * (c - 5)));
      end
      if (c == 13) check("b2b_tail", 64'(out_valid), 64'(0));
      in_valid = (c < 8);
      a = 32'(c);
      b = 32'(c);
      cin = 1'b0;
      sub = 1'b0;
    end

    // Stall for three edges with out_valid high; a set offered during the stall must not enter.
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      case (c)
        0, 1, 2: begin
          in_valid = 1'b1;
          a = 32'h100 * (c + 1);
          b = 32'h1;
        end
        5: begin
          in_valid = 1'b0;
          check("stl_v0", 64'(out_valid), 64'(1));
          check("stl_s0", 64'(sum), 64'h101);
          out_ready = 1'b0;
          #1 check("stl_in_ready", 64'(in_ready), 64'(0));
        end
        6, 7: begin
          in_valid = 1'b1;
          a = 32'hDEAD_0000;
          b = 32'h0;
          check($sformatf("stl_hold_v%0d", c), 64'(out_valid), 64'(1));
          check($sformatf("stl_hold_s%0d", c), 64'(sum), 64'h101);
          check($sformatf("stl_hold_c%0d", c), 64'(cout), 64'(0));
          check($sformatf("stl_rdy%0d", c), 64'(in_ready), 64'(0));
        end
        8: begin
          in_valid = 1'b0;
          check("stl_last_s0", 64'(sum), 64'h101);
          out_ready = 1'b1;
        end
        9: check("stl_s1", 64'(sum), 64'h201);
        10: begin
          check("stl_v2", 64'(out_valid), 64'(1));
          check("stl_s2", 64'(sum), 64'h301);
        end
        11, 12: check($sformatf("stl_none%0d", c), 64'(out_valid), 64'(0));
        default: in_valid = 1'b0;
      endcase
    end

    // Reset with three transactions in flight; nothing stale may emerge afterwards.
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        in_valid = 1'b1;
        a = 32'h1000 + 32'(c);
        b = 32'h1;
      end else begin
        in_valid = 1'b0;
      end
      if (c == 3) begin
        rst_n = 1'b0;
        #1 check("rip_out_valid", 64'(out_valid), 64'(0));
      end
      if (c == 4) rst_n = 1'b1;
      if (c >= 5) check($sformatf("rip_stale%0d", c), 64'(out_valid), 64'(0));
      if (c == 5) check("rip_in_ready", 64'(in_ready), 64'(1));
    end
    send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
